ysyx_22041211_sram_resp: RTL and testbench

Memory responder serving the core's instruction-fetch and load/store requests over a valid/ready request/response handshake. It replaces the zero-latency DPI memory model with a synthesizable word array, configurable access latency and byte-lane handling. Loads are returned right-aligned to bit 0, so the core's existing sign/zero extension logic is unchanged. One outstanding request at a time; one instance per port (IF or LSU).

---
 rtl/ysyx_22041211_mem_pkg.sv | 33 +++
 rtl/ysyx_22041211_lfsr4.sv | 33 +++
 rtl/ysyx_22041211_sram_resp.sv | 178 +++++++++++++++++
 tb/tb_ysyx_22041211_sram_resp.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22041211_mem_pkg.sv
// Shared types and constants for the SRAM responder.
//   state_e          : responder FSM states
//   MASK_B/H/W       : request size codes carried on req_wmask
//   DEFAULT_BASE_ADDR: byte address mapped to word 0
//   size_fault()     : size code / lane alignment check
package ysyx_22041211_mem_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [7:0]  MASK_B            = 8'h01;
    localparam logic [7:0]  MASK_H            = 8'h03;
    localparam logic [7:0]  MASK_W            = 8'h0F;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

    // 1 when the size code is unknown or the access is not naturally aligned
    function automatic logic size_fault(input logic [7:0] mask, input logic [1:0] lane);
        logic f;
        case (mask)
            MASK_B:  f = 1'b0;
            MASK_H:  f = lane[0];
            MASK_W:  f = (lane != 2'd0);
            default: f = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/ysyx_22041211_lfsr4.sv
// 4-bit Fibonacci LFSR, polynomial x^4+x^3+1, seed 4'b1001.
//   clk_i, rst_ni : clock, async active-low reset
//   en_i          : advance one step
//   lfsr_o        : current register value
module ysyx_22041211_lfsr4 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    output logic [3:0] lfsr_o
);

    logic [3:0] lfsr_q;
    logic [3:0] lfsr_d;

    // Shift left, feedback from bits 3 and 2
    always_comb begin
        lfsr_d = lfsr_q;
        if (en_i) begin
            lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= 4'b1001;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/ysyx_22041211_sram_resp.sv
// Word-array memory responder with configurable latency and byte lanes.
// One outstanding request; loads return right-aligned, stores/faults return 0.
// Optional: define SRAM_RESP_RAND_DELAY_EN to add 0..3 LFSR-driven extra cycles
// of latency per request.
//   clk_i, rst_ni          : clock, async active-low reset
//   req_valid_i/req_ready_o: request handshake
//   req_wen_i, req_addr_i, req_wdata_i, req_wmask_i : request payload
//   rsp_valid_o/rsp_ready_i: response handshake
//   rsp_rdata_o, rsp_err_o : response payload
module ysyx_22041211_sram_resp
    import ysyx_22041211_mem_pkg::*;
#(
    parameter int unsigned           DATA_LEN   = 32,
    parameter int unsigned           ADDR_LEN   = 32,
    parameter int unsigned           DEPTH_LOG2 = 12,
    parameter logic [ADDR_LEN-1:0]   BASE_ADDR  = ADDR_LEN'(DEFAULT_BASE_ADDR),
    parameter int unsigned           LATENCY    = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_wen_i,
    input  logic [ADDR_LEN-1:0] req_addr_i,
    input  logic [DATA_LEN-1:0] req_wdata_i,
    input  logic [7:0]          req_wmask_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DATA_LEN-1:0] rsp_rdata_o,
    output logic                rsp_err_o
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    wen_q;
    logic                    fault_q;
    logic [DEPTH_LOG2-1:0]   index_q;
    logic [1:0]              lane_q;
    logic [3:0]              size_q;
    logic [DATA_LEN-1:0]     wdata_q;
    logic                    req_ready_q;
    logic                    rsp_valid_q;
    logic [DATA_LEN-1:0]     rsp_rdata_q;
    logic                    rsp_err_q;

    logic [DATA_LEN-1:0]     mem_q [DEPTH];

    logic [ADDR_LEN-1:0]     offset_c;
    logic                    fault_c;
    logic                    accept_c;
    logic                    commit_c;
    logic                    mem_we_c;
    logic [CNT_W-1:0]        cnt_load_c;
    logic [4:0]              lane_shift_c;
    logic [3:0]              wbe_c;
    logic [DATA_LEN-1:0]     wdata_sh_c;
    logic [DATA_LEN-1:0]     size_mask_c;
    logic [DATA_LEN-1:0]     rdata_d;

    // Request decode: offset wraps modulo 2^ADDR_LEN, so addresses below BASE_ADDR land out of range
    assign offset_c = req_addr_i - BASE_ADDR;
    assign fault_c  = ((offset_c >> (DEPTH_LOG2 + 2)) != '0) ||
                      size_fault(req_wmask_i, offset_c[1:0]);
    assign accept_c = req_valid_i && req_ready_q;
    assign commit_c = (state_q == ST_WAIT) && (cnt_q == '0);
    assign mem_we_c = commit_c && wen_q && !fault_q;

`ifdef SRAM_RESP_RAND_DELAY_EN
    logic [3:0] lfsr_c;
    logic [1:0] unused_lfsr_hi_c;

    ysyx_22041211_lfsr4 u_lfsr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (accept_c),
        .lfsr_o (lfsr_c)
    );

    // Extra delay uses the LFSR value before this acceptance steps it
    assign unused_lfsr_hi_c = lfsr_c[3:2];
    assign cnt_load_c       = CNT_W'(LATENCY - 1) + CNT_W'(lfsr_c[1:0]);
`else
    assign cnt_load_c = CNT_W'(LATENCY - 1);
`endif

    // Lane alignment for both directions and size masking of load data
    always_comb begin
        lane_shift_c = {lane_q, 3'b000};
        wbe_c        = 4'(size_q << lane_q);
        wdata_sh_c   = wdata_q << lane_shift_c;
        case (size_q)
            MASK_B[3:0]: size_mask_c = DATA_LEN'(32'h0000_00FF);
            MASK_H[3:0]: size_mask_c = DATA_LEN'(32'h0000_FFFF);
            default:     size_mask_c = '1;
        endcase
        rdata_d = '0;
        if (!wen_q && !fault_q) begin
            rdata_d = (mem_q[index_q] >> lane_shift_c) & size_mask_c;
        end
    end

    // Array has no reset so contents survive rst_ni
    always_ff @(posedge clk_i) begin
        if (mem_we_c) begin
            for (int b = 0; b < 4; b++) begin
                if (wbe_c[b]) begin
                    mem_q[index_q][8*b +: 8] <= wdata_sh_c[8*b +: 8];
                end
            end
        end
    end

    // Control FSM with registered handshake and response outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            wen_q       <= 1'b0;
            fault_q     <= 1'b0;
            index_q     <= '0;
            lane_q      <= '0;
            size_q      <= '0;
            wdata_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_c) begin
                        state_q     <= ST_WAIT;
                        cnt_q       <= cnt_load_c;
                        wen_q       <= req_wen_i;
                        fault_q     <= fault_c;
                        index_q     <= offset_c[DEPTH_LOG2+1:2];
                        lane_q      <= offset_c[1:0];
                        size_q      <= req_wmask_i[3:0];
                        wdata_q     <= req_wdata_i;
                        req_ready_q <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (commit_c) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rdata_d;
                        rsp_err_q   <= fault_q;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        state_q     <= ST_IDLE;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_ysyx_22041211_sram_resp.sv
// Directed bench for ysyx_22041211_sram_resp.
// Three instances share clock and reset: LATENCY=1, LATENCY=3, LATENCY=2.
module tb_ysyx_22041211_sram_resp;

`ifdef SRAM_RESP_RAND_DELAY_EN
    localparam bit RAND = 1'b1;
`else
    localparam bit RAND = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;

    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_wen   [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [7:0]  req_wmask [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ysyx_22041211_sram_resp #(.LATENCY(1)) dut_l1 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_wen_i(req_wen[0]),
        .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]), .req_wmask_i(req_wmask[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
        .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0])
    );

    ysyx_22041211_sram_resp #(.LATENCY(3)) dut_l3 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_wen_i(req_wen[1]),
        .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]), .req_wmask_i(req_wmask[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
        .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1])
    );

    ysyx_22041211_sram_resp #(.LATENCY(2)) dut_l2 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid[2]), .req_ready_o(req_ready[2]), .req_wen_i(req_wen[2]),
        .req_addr_i(req_addr[2]), .req_wdata_i(req_wdata[2]), .req_wmask_i(req_wmask[2]),
        .rsp_valid_o(rsp_valid[2]), .rsp_ready_i(rsp_ready[2]),
        .rsp_rdata_o(rsp_rdata[2]), .rsp_err_o(rsp_err[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request/response on port p; response consumed as soon as it appears
    task automatic xfer(input int p, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [7:0] mask,
                        output logic [31:0] rdata, output logic err, output int lat);
        req_wen[p]   = wen;
        req_addr[p]  = addr;
        req_wdata[p] = wdata;
        req_wmask[p] = mask;
        req_valid[p] = 1'b1;
        @(posedge clk); #1;
        req_valid[p] = 1'b0;
        lat = 0;
        while (!rsp_valid[p] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = rsp_rdata[p];
        err   = rsp_err[p];
        rsp_ready[p] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[p] = 1'b0;
    endtask

    task automatic access(input string tag, input int p, input logic wen,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [7:0] mask, input logic [31:0] exp_rdata,
                          input logic exp_err, input int exp_lat, input bit exact);
        logic [31:0] rd;
        logic        er;
        int          lat;
        xfer(p, wen, addr, wdata, mask, rd, er, lat);
        chk({tag, "_rdata"}, rd, exp_rdata);
        chk({tag, "_err"}, 32'(er), 32'(exp_err));
        if (exact) begin
            chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        end else begin
            chk({tag, "_latrange"}, 32'(lat >= exp_lat && lat <= exp_lat + 3), 32'd1);
        end
        chk({tag, "_rdy"}, 32'(req_ready[p]), 32'd1);
    endtask

    initial begin
        logic [3:0] model;
        int         n;
        bit         ex;

        ex = !RAND;
        for (int i = 0; i < 3; i++) begin
            req_valid[i] = 1'b0; req_wen[i] = 1'b0; req_addr[i] = '0;
            req_wdata[i] = '0;   req_wmask[i] = '0; rsp_ready[i] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(rsp_valid[0]), 32'd0);
        chk("rst_rdata", rsp_rdata[0], 32'd0);
        chk("rst_err", 32'(rsp_err[0]), 32'd0);
        chk("rst_ready", 32'(req_ready[0]), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic word store/load at LATENCY=1
        access("st_w",  0, 1'b1, 32'h8000_0000, 32'hDEAD_BEEF, 8'h0F, 32'h0, 1'b0, 1, ex);
        access("ld_w",  0, 1'b0, 32'h8000_0000, 32'h0,         8'h0F, 32'hDEAD_BEEF, 1'b0, 1, ex);

        // Byte and half lanes
        access("st_z",  0, 1'b1, 32'h8000_0000, 32'h0,         8'h0F, 32'h0, 1'b0, 1, ex);
        access("st_b3", 0, 1'b1, 32'h8000_0003, 32'h0000_00A5, 8'h01, 32'h0, 1'b0, 1, ex);
        access("ld_w2", 0, 1'b0, 32'h8000_0000, 32'h0,         8'h0F, 32'hA500_0000, 1'b0, 1, ex);
        access("ld_h2", 0, 1'b0, 32'h8000_0002, 32'h0,         8'h03, 32'h0000_A500, 1'b0, 1, ex);
        access("ld_b3", 0, 1'b0, 32'h8000_0003, 32'h0,         8'h01, 32'h0000_00A5, 1'b0, 1, ex);
        access("ld_b2", 0, 1'b0, 32'h8000_0002, 32'h0,         8'h01, 32'h0, 1'b0, 1, ex);
        access("st_h2", 0, 1'b1, 32'h8000_0002, 32'h1234_BEEF, 8'h03, 32'h0, 1'b0, 1, ex);
        access("ld_w3", 0, 1'b0, 32'h8000_0000, 32'h0,         8'h0F, 32'hBEEF_0000, 1'b0, 1, ex);
        access("ld_b2b",0, 1'b0, 32'h8000_0002, 32'h0,         8'h01, 32'h0000_00EF, 1'b0, 1, ex);

        // Faults: no write, rdata 0, err 1
        access("f_low", 0, 1'b0, 32'h7FFF_FFFC, 32'h0,         8'h0F, 32'h0, 1'b1, 1, ex);
        access("f_wal", 0, 1'b1, 32'h8000_0002, 32'hFFFF_FFFF, 8'h0F, 32'h0, 1'b1, 1, ex);
        access("f_hal", 0, 1'b1, 32'h8000_0001, 32'hFFFF_FFFF, 8'h03, 32'h0, 1'b1, 1, ex);
        access("f_msk", 0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 8'h07, 32'h0, 1'b1, 1, ex);
        access("f_high",0, 1'b0, 32'h8000_4000, 32'h0,         8'h0F, 32'h0, 1'b1, 1, ex);
        access("f_keep",0, 1'b0, 32'h8000_0000, 32'h0,         8'h0F, 32'hBEEF_0000, 1'b0, 1, ex);

        // Last valid word
        access("st_top",0, 1'b1, 32'h8000_3FFC, 32'hCAFE_F00D, 8'h0F, 32'h0, 1'b0, 1, ex);
        access("ld_top",0, 1'b0, 32'h8000_3FFC, 32'h0,         8'h0F, 32'hCAFE_F00D, 1'b0, 1, ex);

        // Backpressure at LATENCY=3
        access("bp_st", 1, 1'b1, 32'h8000_0010, 32'h55AA_55AA, 8'h0F, 32'h0, 1'b0, 3, ex);
        req_wen[1] = 1'b0; req_addr[1] = 32'h8000_0010; req_wmask[1] = 8'h0F;
        req_valid[1] = 1'b1;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        chk("bp_wait_rdy", 32'(req_ready[1]), 32'd0);
        n = 0;
        while (!rsp_valid[1] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (ex) chk("bp_lat", 32'(n), 32'd3);
        else    chk("bp_latrange", 32'(n >= 3 && n <= 6), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", 32'(rsp_valid[1]), 32'd1);
            chk("bp_hold_rdata", rsp_rdata[1], 32'h55AA_55AA);
            chk("bp_hold_rdy", 32'(req_ready[1]), 32'd0);
        end
        rsp_ready[1] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[1] = 1'b0;
        chk("bp_rel_rdy", 32'(req_ready[1]), 32'd1);
        chk("bp_rel_valid", 32'(rsp_valid[1]), 32'd0);

        // Reset during WAIT drops the pending store
        access("rw_init", 1, 1'b1, 32'h8000_0020, 32'h0, 8'h0F, 32'h0, 1'b0, 3, ex);
        req_wen[1] = 1'b1; req_addr[1] = 32'h8000_0020;
        req_wdata[1] = 32'h1234_5678; req_wmask[1] = 8'h0F;
        req_valid[1] = 1'b1;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        chk("rw_wait_rdy", 32'(req_ready[1]), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rw_rst_valid", 32'(rsp_valid[1]), 32'd0);
        chk("rw_rst_rdy", 32'(req_ready[1]), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("rw_rst_valid2", 32'(rsp_valid[1]), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        access("rw_ld", 1, 1'b0, 32'h8000_0020, 32'h0, 8'h0F, 32'h0, 1'b0, 3, ex);

`ifdef SRAM_RESP_RAND_DELAY_EN
        // Random extra delay follows the LFSR from its seed
        access("rd_st", 2, 1'b1, 32'h8000_0040, 32'h0BAD_CAFE, 8'h0F, 32'h0, 1'b0, 2, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        model = 4'b1001;
        for (int i = 0; i < 16; i++) begin
            access("rd_ld", 2, 1'b0, 32'h8000_0040, 32'h0, 8'h0F, 32'h0BAD_CAFE, 1'b0,
                   2 + int'(model[1:0]), 1'b1);
            model = {model[2:0], model[3] ^ model[2]};
        end
`else
        model = 4'b0;
        access("l2_st", 2, 1'b1, 32'h8000_0040, 32'h0BAD_CAFE, 8'h0F, 32'h0, 1'b0, 2, 1'b1);
        access("l2_ld", 2, 1'b0, 32'h8000_0040, 32'h0, 8'h0F, 32'h0BAD_CAFE, 1'b0,
               2 + int'(model[1:0]), 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
